jtdsp16_do_loop: RTL and testbench

- Sequencer for the DSP16 `do K { NI instructions }` / `redo K` hardware loop.
- Takes `do_start`/`do_data` from the instruction controller.
  - Captures the NI loop-body words from the ROM bus during the first pass into a 15-word instruction cache.
  - Replays the cache for the remaining K-1 passes, selecting cache output onto the instruction path and holding the XAAU program counter.
- Sits between the ROM fetch path, the controller and the XAAU.

---
 rtl/jtdsp16_do_loop_if.sv | 26 ++
 rtl/jtdsp16_do_loop.sv | 128 ++++++++++++
 tb/tb_jtdsp16_do_loop.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/jtdsp16_do_loop_if.sv
// Controller/ROM-side bundle for the DSP16 do/redo loop sequencer.
// The master drives the decode and fetch signals; the slave is the sequencer.
interface jtdsp16_do_loop_if;
  logic        cen;
  logic        do_start;
  logic [10:0] do_data;
  logic        fetch_adv;
  logic [15:0] rom_dout;
  logic [15:0] cache_dout;
  logic        cache_sel;
  logic        pc_halt;
  logic        busy;
  logic [6:0]  k_left;
  logic [3:0]  ni_len;
  logic        fault;

  modport master (
    output cen, do_start, do_data, fetch_adv, rom_dout,
    input  cache_dout, cache_sel, pc_halt, busy, k_left, ni_len, fault
  );

  modport slave (
    input  cen, do_start, do_data, fetch_adv, rom_dout,
    output cache_dout, cache_sel, pc_halt, busy, k_left, ni_len, fault
  );
endinterface

// File: rtl/jtdsp16_do_loop.sv
// DSP16 `do K { NI }` / `redo K` sequencer: captures the loop body from ROM on
// the first pass into a small cache and replays it for the remaining passes.
module jtdsp16_do_loop #(
  parameter int CW = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  jtdsp16_do_loop_if.slave   bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FILL   = 2'd1;
  localparam logic [1:0] S_REPLAY = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic [6:0]  k_left_q, k_left_d;
  logic [3:0]  ni_len_q, ni_len_d;
  logic        fault_q, fault_d;
  logic [15:0] cache_q [0:CW-1];
  logic [15:0] cache_d [0:CW-1];

  logic [3:0]  do_ni;
  logic [6:0]  do_k;
  logic        last_word;
  logic        eop;
  logic [6:0]  k_cur;

  assign do_ni     = bus.do_data[10:7];
  assign do_k      = bus.do_data[6:0];
  assign last_word = (idx_q == ni_len_q - 4'd1);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    k_left_d = k_left_q;
    ni_len_d = ni_len_q;
    fault_d  = fault_q;
    cache_d  = cache_q;
    eop      = 1'b0;
    k_cur    = k_left_q;
    if (bus.cen) begin
      case (state_q)
        S_IDLE: begin
          if (bus.do_start) begin
            if (do_k == 7'd0) begin
              fault_d = 1'b1;
            end else if (do_ni != 4'd0) begin
              // The decode cycle doubles as fill step 0, so a one-word body
              // can finish its pass without ever entering FILL.
              ni_len_d = do_ni;
              k_left_d = do_k;
              k_cur    = do_k;
              if (bus.fetch_adv) cache_d[0] = bus.rom_dout;
              if (do_ni == 4'd1 && bus.fetch_adv) begin
                eop = 1'b1;
              end else begin
                state_d = S_FILL;
                idx_d   = bus.fetch_adv ? 4'd1 : 4'd0;
              end
            end else if (ni_len_q == 4'd0) begin
              fault_d = 1'b1;
            end else begin
              k_left_d = do_k;
              idx_d    = 4'd0;
              state_d  = S_REPLAY;
            end
          end
        end
        S_FILL: begin
          if (bus.do_start) fault_d = 1'b1;
          if (bus.fetch_adv) begin
            cache_d[idx_q] = bus.rom_dout;
            if (last_word) eop = 1'b1;
            else           idx_d = idx_q + 4'd1;
          end
        end
        S_REPLAY: begin
          if (bus.do_start) fault_d = 1'b1;
          if (bus.fetch_adv) begin
            if (last_word) eop = 1'b1;
            else           idx_d = idx_q + 4'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase

      if (eop) begin
        idx_d = 4'd0;
        if (k_cur == 7'd1) begin
          state_d  = S_IDLE;
          k_left_d = 7'd0;
        end else begin
          k_left_d = k_cur - 7'd1;
          state_d  = S_REPLAY;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      idx_q    <= 4'd0;
      k_left_q <= 7'd0;
      ni_len_q <= 4'd0;
      fault_q  <= 1'b0;
      for (int i = 0; i < CW; i++) cache_q[i] <= 16'd0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      k_left_q <= k_left_d;
      ni_len_q <= ni_len_d;
      fault_q  <= fault_d;
      for (int i = 0; i < CW; i++) cache_q[i] <= cache_d[i];
    end
  end

  // Control outputs come from the registered state, one cen cycle behind.
  assign bus.cache_dout = cache_q[idx_q];
  assign bus.cache_sel  = (state_q == S_REPLAY);
  assign bus.pc_halt    = (state_q == S_REPLAY);
  assign bus.busy       = (state_q == S_FILL) || (state_q == S_REPLAY);
  assign bus.k_left     = k_left_q;
  assign bus.ni_len     = ni_len_q;
  assign bus.fault      = fault_q;

endmodule

// File: tb/tb_jtdsp16_do_loop.sv
// Bench for jtdsp16_do_loop: vector table plus hand sequences, with expected
// outputs queued at drive time and compared after each clock edge.
module tb_jtdsp16_do_loop;

  logic clk;
  logic rst_n;

  jtdsp16_do_loop_if bus ();

  jtdsp16_do_loop #(.CW(15)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          cen;
    bit          ds;
    logic [3:0]  ni;
    logic [6:0]  k;
    bit          fa;
    logic [15:0] rom;
    bit          e_sel;
    bit          e_busy;
    logic [15:0] e_dout;
    logic [6:0]  e_k;
    logic [3:0]  e_ni;
    bit          e_fault;
  } vec_t;

  localparam logic [15:0] WA = 16'hA001;
  localparam logic [15:0] WB = 16'hB002;
  localparam logic [15:0] WC = 16'hC003;
  localparam logic [15:0] WD = 16'hD004;
  localparam logic [15:0] WE = 16'hE005;
  localparam logic [15:0] WF = 16'hF006;
  localparam logic [15:0] WX = 16'h1111;

  int   total;
  int   bad;
  vec_t vecs[$];
  vec_t sb[$];

  function automatic vec_t mk(bit cen, bit ds, logic [3:0] ni, logic [6:0] k,
                              bit fa, logic [15:0] rom, bit sel, bit busy,
                              logic [15:0] dout, logic [6:0] ek,
                              logic [3:0] eni, bit ef);
    vec_t v;
    v.cen = cen; v.ds = ds; v.ni = ni; v.k = k; v.fa = fa; v.rom = rom;
    v.e_sel = sel; v.e_busy = busy; v.e_dout = dout; v.e_k = ek;
    v.e_ni = eni; v.e_fault = ef;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_out(input vec_t e, input string tag);
    chk({tag, " cache_sel"},  {31'd0, bus.cache_sel}, {31'd0, e.e_sel});
    chk({tag, " pc_halt"},    {31'd0, bus.pc_halt},   {31'd0, e.e_sel});
    chk({tag, " busy"},       {31'd0, bus.busy},      {31'd0, e.e_busy});
    chk({tag, " cache_dout"}, {16'd0, bus.cache_dout}, {16'd0, e.e_dout});
    chk({tag, " k_left"},     {25'd0, bus.k_left},    {25'd0, e.e_k});
    chk({tag, " ni_len"},     {28'd0, bus.ni_len},    {28'd0, e.e_ni});
    chk({tag, " fault"},      {31'd0, bus.fault},     {31'd0, e.e_fault});
  endtask

  task automatic drive_idle();
    bus.cen = 1'b1; bus.do_start = 1'b0; bus.do_data = 11'd0;
    bus.fetch_adv = 1'b0; bus.rom_dout = 16'd0;
  endtask

  task automatic step(input vec_t v, input string tag);
    vec_t e;
    bus.cen       = v.cen;
    bus.do_start  = v.ds;
    bus.do_data   = {v.ni, v.k};
    bus.fetch_adv = v.fa;
    bus.rom_dout  = v.rom;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_out(e, tag);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    #1;
    check_out(mk(0,0,0,0,0,0, 0,0,16'd0,7'd0,4'd0,0), "reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive_idle();

    // do NI=3 K=2, one cen=0 hold cycle in the replay
    vecs.push_back(mk(1,1,3,2,1,WA, 0,1,16'd0,2,3,0));
    vecs.push_back(mk(1,0,0,0,1,WB, 0,1,16'd0,2,3,0));
    vecs.push_back(mk(1,0,0,0,1,WC, 1,1,WA,1,3,0));
    vecs.push_back(mk(1,0,0,0,1,WX, 1,1,WB,1,3,0));
    vecs.push_back(mk(0,0,0,0,1,WX, 1,1,WB,1,3,0));
    vecs.push_back(mk(1,0,0,0,1,WX, 1,1,WC,1,3,0));
    vecs.push_back(mk(1,0,0,0,1,WX, 0,0,WA,0,3,0));
    // redo K=3: nine replay cycles
    vecs.push_back(mk(1,1,0,3,1,WX, 1,1,WA,3,3,0));
    vecs.push_back(mk(1,0,0,0,1,WX, 1,1,WB,3,3,0));
    vecs.push_back(mk(1,0,0,0,1,WX, 1,1,WC,3,3,0));
    vecs.push_back(mk(1,0,0,0,1,WX, 1,1,WA,2,3,0));
    vecs.push_back(mk(1,0,0,0,1,WX, 1,1,WB,2,3,0));
    vecs.push_back(mk(1,0,0,0,1,WX, 1,1,WC,2,3,0));
    vecs.push_back(mk(1,0,0,0,1,WX, 1,1,WA,1,3,0));
    vecs.push_back(mk(1,0,0,0,1,WX, 1,1,WB,1,3,0));
    vecs.push_back(mk(1,0,0,0,1,WX, 1,1,WC,1,3,0));
    vecs.push_back(mk(1,0,0,0,1,WX, 0,0,WA,0,3,0));
    // do NI=1 K=1: done in the decode cycle
    vecs.push_back(mk(1,1,1,1,1,WD, 0,0,WD,0,1,0));
    vecs.push_back(mk(1,0,0,0,0,WX, 0,0,WD,0,1,0));
    // do NI=2 K=2 with fill and replay stalls
    vecs.push_back(mk(1,1,2,2,1,WE, 0,1,WB,2,2,0));
    vecs.push_back(mk(1,0,0,0,0,WF, 0,1,WB,2,2,0));
    vecs.push_back(mk(1,0,0,0,1,WF, 1,1,WE,1,2,0));
    vecs.push_back(mk(1,0,0,0,1,WX, 1,1,WF,1,2,0));
    vecs.push_back(mk(1,0,0,0,0,WX, 1,1,WF,1,2,0));
    vecs.push_back(mk(1,0,0,0,0,WX, 1,1,WF,1,2,0));
    vecs.push_back(mk(1,0,0,0,1,WX, 0,0,WE,0,2,0));

    do_reset();
    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("vec%0d", i));

    // redo straight after reset is illegal
    do_reset();
    step(mk(1,1,0,3,1,WX, 0,0,16'd0,0,0,1), "redo_nolen");
    step(mk(1,0,0,0,1,WX, 0,0,16'd0,0,0,1), "redo_nolen_hold");

    // K=0 is illegal, fault must have been cleared by the reset
    do_reset();
    step(mk(1,1,2,0,1,WX, 0,0,16'd0,0,0,1), "k_zero");

    // do_start during replay flags fault but the loop finishes
    do_reset();
    step(mk(1,1,2,2,1,WE, 0,1,16'd0,2,2,0), "busy_fill");
    step(mk(1,0,0,0,1,WF, 1,1,WE,1,2,0), "busy_rep0");
    step(mk(1,1,3,5,1,WX, 1,1,WF,1,2,1), "busy_dostart");
    step(mk(1,0,0,0,1,WX, 0,0,WE,0,2,1), "busy_done");

    // asynchronous reset in the middle of a replay pass
    do_reset();
    step(mk(1,1,2,2,1,WE, 0,1,16'd0,2,2,0), "mid_fill");
    step(mk(1,0,0,0,1,WF, 1,1,WE,1,2,0), "mid_rep0");
    step(mk(1,0,0,0,1,WX, 1,1,WF,1,2,0), "mid_rep1");
    #2;
    rst_n = 1'b0;
    #1;
    check_out(mk(0,0,0,0,0,0, 0,0,16'd0,0,0,0), "mid_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(mk(1,1,2,2,1,16'h1234, 0,1,16'd0,2,2,0), "post_fill");
    step(mk(1,0,0,0,1,16'h5678, 1,1,16'h1234,1,2,0), "post_rep0");
    step(mk(1,0,0,0,1,WX, 1,1,16'h5678,1,2,0), "post_rep1");
    step(mk(1,0,0,0,1,WX, 0,0,16'h1234,0,2,0), "post_done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
